// File: rtl/bram_sched.sv
// bram_sched: four-phase scheduler for the shared instruction/data BRAM.
//
// Rotation: I1 (instruction fetch 1) -> I2 (instruction fetch 2) ->
//           D (data access) -> G (global write) -> I1 ...
// The single data slot of each rotation goes to the processor or to the
// host/loader port. The decision is taken from inputs sampled in I2. A
// starvation counter forces the slot to the host after STARVE_LIMIT-1
// consecutive denied contested rotations.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_dacc/dwe/daddr/din        processor data request
//   host_req/we/addr/din          host data request (held until host_gnt)
//   mem_dout                      bram read data
//   i1re, i2re, dre, gwe          one-hot phase strobes
//   dwe, daddr, din               muxed data port towards the bram
//   host_gnt                      host access performed this cycle (D)
//   host_rvalid, host_rdata       host read data, valid in G
//   cpu_stall                     processor lost the slot (D and G)
//   phase                         current phase (0=I1,1=I2,2=D,3=G)
module bram_sched #(
  parameter int WORD_SIZE    = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_dacc,
  input  logic                 cpu_dwe,
  input  logic [15:0]          cpu_daddr,
  input  logic [WORD_SIZE-1:0] cpu_din,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [15:0]          host_addr,
  input  logic [WORD_SIZE-1:0] host_din,
  input  logic [WORD_SIZE-1:0] mem_dout,
  output logic                 i1re,
  output logic                 i2re,
  output logic                 dre,
  output logic                 gwe,
  output logic                 dwe,
  output logic [15:0]          daddr,
  output logic [WORD_SIZE-1:0] din,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [WORD_SIZE-1:0] host_rdata,
  output logic                 cpu_stall,
  output logic [1:0]           phase
);

  typedef enum logic [1:0] {
    PH_I1 = 2'd0,
    PH_I2 = 2'd1,
    PH_D  = 2'd2,
    PH_G  = 2'd3
  } phase_t;

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

  phase_t     phase_q;
  logic       owner_host_q;  // registered owner of the current rotation's data slot
  logic       dacc_q;        // cpu_dacc as sampled in I2
  logic       host_rd_q;     // preceding D was a host read
  logic [3:0] starve_q;
  logic       grant_host;
  logic       run;

  // Arbitration for the data slot, evaluated on the I2 inputs.
  always_comb begin
    grant_host = host_req && (!cpu_dacc || (starve_q == STARVE_LAST));
  end

  // Phase rotation, owner decision, starvation count and read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_I1;
      owner_host_q <= 1'b0;
      dacc_q       <= 1'b0;
      host_rd_q    <= 1'b0;
      starve_q     <= 4'd0;
    end else begin
      phase_q <= phase_t'(phase_q + 2'd1);
      case (phase_q)
        PH_I2: begin
          owner_host_q <= grant_host;
          dacc_q       <= cpu_dacc;
          if (host_req && !grant_host) begin
            starve_q <= (starve_q == 4'd15) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_q <= 4'd0;
          end
        end
        // bram read latency is one cycle, so a host read in D returns in G.
        PH_D:    host_rd_q <= owner_host_q && !host_we;
        PH_G:    host_rd_q <= 1'b0;
        default: host_rd_q <= host_rd_q;
      endcase
    end
  end

  // Output decode from registered state; reset forces every strobe low,
  // which also discards a host grant caught mid-rotation.
  always_comb begin
    run         = !rst;
    i1re        = run && (phase_q == PH_I1);
    i2re        = run && (phase_q == PH_I2);
    dre         = run && (phase_q == PH_D);
    cpu_stall   = run && owner_host_q && dacc_q &&
                  ((phase_q == PH_D) || (phase_q == PH_G));
    gwe         = run && (phase_q == PH_G) && !cpu_stall;
    host_gnt    = run && (phase_q == PH_D) && owner_host_q;
    host_rvalid = run && (phase_q == PH_G) && host_rd_q;
    if (owner_host_q) begin
      dwe   = dre && host_we;
      daddr = host_addr;
      din   = host_din;
    end else begin
      dwe   = dre && cpu_dwe && cpu_dacc;
      daddr = cpu_daddr;
      din   = cpu_din;
    end
    host_rdata = mem_dout;
    phase      = phase_q;
  end

endmodule

// File: tb/tb_bram_sched.sv
// Directed self-checking bench for bram_sched.
module tb_bram_sched;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_dacc, cpu_dwe;
  logic [15:0]  cpu_daddr;
  logic [W-1:0] cpu_din;
  logic         host_req, host_we;
  logic [15:0]  host_addr;
  logic [W-1:0] host_din, mem_dout;
  logic         i1re, i2re, dre, gwe, dwe;
  logic [15:0]  daddr;
  logic [W-1:0] din;
  logic         host_gnt, host_rvalid, cpu_stall;
  logic [W-1:0] host_rdata;
  logic [1:0]   phase;

  int checks   = 0;
  int failures = 0;

  bram_sched #(.WORD_SIZE(W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_dacc(cpu_dacc), .cpu_dwe(cpu_dwe), .cpu_daddr(cpu_daddr), .cpu_din(cpu_din),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
    .mem_dout(mem_dout),
    .i1re(i1re), .i2re(i2re), .dre(dre), .gwe(gwe),
    .dwe(dwe), .daddr(daddr), .din(din),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .cpu_stall(cpu_stall), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance into the next cycle; outputs are settled 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full rotation starting in I1 with inputs already applied; ends in the next I1.
  task automatic run_rot(input string tag, input logic exp_host, input logic exp_stall,
                         input logic [15:0] exp_addr, input logic exp_dwe,
                         input logic [W-1:0] exp_din, input logic exp_rv,
                         input logic [W-1:0] rdat);
    check_eq({tag, "_i1"}, {30'd0, phase}, 32'd0);
    next_cycle();
    check_eq({tag, "_i2re"}, {31'd0, i2re}, 32'd1);
    next_cycle();
    check_eq({tag, "_dre"},   {31'd0, dre}, 32'd1);
    check_eq({tag, "_gnt"},   {31'd0, host_gnt}, {31'd0, exp_host});
    check_eq({tag, "_dstall"},{31'd0, cpu_stall}, {31'd0, exp_stall});
    check_eq({tag, "_daddr"}, {16'd0, daddr}, {16'd0, exp_addr});
    check_eq({tag, "_dwe"},   {31'd0, dwe}, {31'd0, exp_dwe});
    if (exp_dwe) check_eq({tag, "_din"}, {16'd0, din}, {16'd0, exp_din});
    next_cycle();
    mem_dout = rdat;
    #1;
    check_eq({tag, "_gwe"},    {31'd0, gwe}, {31'd0, !exp_stall});
    check_eq({tag, "_gstall"}, {31'd0, cpu_stall}, {31'd0, exp_stall});
    check_eq({tag, "_gnt_g"},  {31'd0, host_gnt}, 32'd0);
    check_eq({tag, "_dwe_g"},  {31'd0, dwe}, 32'd0);
    check_eq({tag, "_rvalid"}, {31'd0, host_rvalid}, {31'd0, exp_rv});
    if (exp_rv) check_eq({tag, "_rdata"}, {16'd0, host_rdata}, {16'd0, rdat});
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    cpu_dacc = 1'b0; cpu_dwe = 1'b0; cpu_daddr = 16'h0000; cpu_din = 16'h0000;
    host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0000; host_din = 16'h0000;
    mem_dout = 16'h0000;

    // Reset state.
    next_cycle();
    check_eq("rst_phase", {30'd0, phase}, 32'd0);
    check_eq("rst_strobes", {28'd0, i1re, i2re, dre, gwe}, 32'd0);
    check_eq("rst_gnt", {31'd0, host_gnt}, 32'd0);
    next_cycle();
    rst = 1'b0;
    #1;

    // Idle rotations: one-hot strobes in order, twice.
    for (int k = 0; k < 8; k++) begin
      check_eq("idle_phase", {30'd0, phase}, k % 4);
      check_eq("idle_strobes", {28'd0, i1re, i2re, dre, gwe}, 32'd8 >> (k % 4));
      check_eq("idle_dwe", {31'd0, dwe}, 32'd0);
      check_eq("idle_gnt", {31'd0, host_gnt}, 32'd0);
      next_cycle();
    end

    // Processor write.
    cpu_dacc = 1'b1; cpu_dwe = 1'b1; cpu_daddr = 16'h0010; cpu_din = 16'hBEEF;
    run_rot("cpu_wr", 1'b0, 1'b0, 16'h0010, 1'b1, 16'hBEEF, 1'b0, 16'h0000);
    cpu_dacc = 1'b0; cpu_dwe = 1'b0;

    // Host read with idle processor.
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
    run_rot("host_rd", 1'b1, 1'b0, 16'h0020, 1'b0, 16'h0000, 1'b1, 16'h1234);
    host_req = 1'b0;

    // Contested: CPU wins three rotations, host forced on the fourth, CPU on the fifth.
    cpu_dacc = 1'b1; cpu_dwe = 1'b0; cpu_daddr = 16'h0030;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0040; host_din = 16'hCAFE;
    for (int r = 1; r <= 5; r++) begin
      if (r == 4) run_rot("starve_host", 1'b1, 1'b1, 16'h0040, 1'b1, 16'hCAFE, 1'b0, 16'h0000);
      else        run_rot("starve_cpu",  1'b0, 1'b0, 16'h0030, 1'b0, 16'h0000, 1'b0, 16'h0000);
    end
    cpu_dacc = 1'b0;

    // Reset during D of a host read rotation.
    host_we = 1'b0; host_addr = 16'h0060;
    next_cycle();
    next_cycle();
    check_eq("rstd_gnt_before", {31'd0, host_gnt}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rstd_gnt_forced", {31'd0, host_gnt}, 32'd0);
    check_eq("rstd_dre_forced", {31'd0, dre}, 32'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    check_eq("rstd_phase_i1", {30'd0, phase}, 32'd0);
    check_eq("rstd_i1re", {31'd0, i1re}, 32'd1);
    check_eq("rstd_rvalid", {31'd0, host_rvalid}, 32'd0);
    cpu_dacc = 1'b1; cpu_daddr = 16'h0070;
    run_rot("rstd_cpu", 1'b0, 1'b0, 16'h0070, 1'b0, 16'h0000, 1'b0, 16'h5555);
    host_req = 1'b0; cpu_dacc = 1'b0;

    // Host request dropped before I2 is not granted.
    host_req = 1'b1; host_we = 1'b1; cpu_daddr = 16'h0080;
    next_cycle();
    host_req = 1'b0;
    #1;
    check_eq("drop_phase_i2", {30'd0, phase}, 32'd1);
    next_cycle();
    check_eq("drop_gnt", {31'd0, host_gnt}, 32'd0);
    check_eq("drop_daddr", {16'd0, daddr}, 32'h0080);
    check_eq("drop_dwe", {31'd0, dwe}, 32'd0);
    next_cycle();
    check_eq("drop_rvalid", {31'd0, host_rvalid}, 32'd0);
    check_eq("drop_gwe", {31'd0, gwe}, 32'd1);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
